interp_window_sequencer: RTL and testbench

Parametrised successor to the row/column input mux of the subpixel interpolation datapath. It latches one block of integer pixels and the horizontal half-pel planes, then autonomously streams filter-window vectors (integer rows, transposed integer columns, half-pel columns) to the 8-tap filter bank over a valid/ready handshake, replacing the externally driven `sel` index. It supports both interpolation rounds through a mode input.

---
 rtl/interp_seq_pkg.sv | 38 +++
 rtl/interp_column_extract.sv | 19 +
 rtl/interp_window_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_interp_window_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_seq_pkg.sv
// Shared types, encodings and sizing helpers for the interpolation window sequencer.
package interp_seq_pkg;

  localparam int unsigned DEF_NUM_PIXEL = 8;
  localparam int unsigned DEF_TAPS      = 8;
  localparam int unsigned DEF_PIXEL_W   = 8;
  localparam int unsigned DEF_NUM_HALF  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INT_ROW,
    ST_INT_COL,
    ST_HALF,
    ST_DONE
  } state_e;

  localparam logic [1:0] KIND_INT_ROW = 2'd0;
  localparam logic [1:0] KIND_INT_COL = 2'd1;
  localparam logic [1:0] KIND_HALF    = 2'd2;

  function automatic int unsigned win_size(input int unsigned num_pixel, input int unsigned taps);
    return num_pixel + taps - 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Beat kind reported on out_kind for each streaming state.
  function automatic logic [1:0] kind_of_state(input state_e s);
    case (s)
      ST_INT_COL: return KIND_INT_COL;
      ST_HALF:    return KIND_HALF;
      default:    return KIND_INT_ROW;
    endcase
  endfunction

endpackage

// File: rtl/interp_column_extract.sv
// Gathers one column of the latched integer block into a window vector, row 0 at LSBs.
module interp_column_extract #(
  parameter int unsigned WIN     = 15,
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned IDX_W   = 4
) (
  input  logic [WIN*WIN*PIXEL_W-1:0] pixels,
  input  logic [IDX_W-1:0]           col,
  output logic [WIN*PIXEL_W-1:0]     column_c
);

  always_comb begin
    column_c = '0;
    for (int unsigned j = 0; j < WIN; j++) begin
      column_c[j*PIXEL_W +: PIXEL_W] = pixels[PIXEL_W*(j*WIN + int'(col)) +: PIXEL_W];
    end
  end

endmodule

// File: rtl/interp_window_sequencer.sv
// Streams integer rows, integer columns and half-pel columns of a latched block to the filter bank.
// Optional backpressure counter on stall_count enabled by INTERP_SEQ_STALL_CNT_EN.
module interp_window_sequencer
  import interp_seq_pkg::*;
#(
  parameter int unsigned NUM_PIXEL = DEF_NUM_PIXEL,
  parameter int unsigned TAPS      = DEF_TAPS,
  parameter int unsigned PIXEL_W   = DEF_PIXEL_W,
  parameter int unsigned NUM_HALF  = DEF_NUM_HALF
) (
  input  logic                                                              clock,
  input  logic                                                              reset,
  input  logic                                                              start,
  input  logic                                                              mode,
  input  logic [win_size(NUM_PIXEL, TAPS)*win_size(NUM_PIXEL, TAPS)*PIXEL_W-1:0] integer_array,
  input  logic [NUM_HALF*NUM_PIXEL*win_size(NUM_PIXEL, TAPS)*PIXEL_W-1:0]     half_array,
  output logic                                                              out_valid,
  input  logic                                                              out_ready,
  output logic [win_size(NUM_PIXEL, TAPS)*PIXEL_W-1:0]                      out_data,
  output logic [1:0]                                                        out_kind,
  output logic [1:0]                                                        out_plane,
  output logic [idx_width(win_size(NUM_PIXEL, TAPS))-1:0]                   out_index,
  output logic                                                              out_last,
  output logic                                                              busy,
  output logic                                                              done,
  output logic [15:0]                                                       stall_count
);

  localparam int unsigned WIN    = win_size(NUM_PIXEL, TAPS);
  localparam int unsigned IDX_W  = idx_width(WIN);
  localparam int unsigned ROW_W  = WIN * PIXEL_W;
  localparam int unsigned INT_W  = WIN * ROW_W;
  localparam int unsigned HALF_W = NUM_HALF * NUM_PIXEL * ROW_W;
  localparam int unsigned OFF    = TAPS / 2 - 1;

  localparam logic [IDX_W-1:0] ROW_END_FULL = IDX_W'(WIN - 1);
  localparam logic [IDX_W-1:0] CENTER_FIRST = IDX_W'(OFF);
  localparam logic [IDX_W-1:0] CENTER_LAST  = IDX_W'(OFF + NUM_PIXEL - 1);
  localparam logic [IDX_W-1:0] HALF_END     = IDX_W'(NUM_PIXEL - 1);
  localparam logic [1:0]       PLANE_RED    = 2'(NUM_HALF / 2);
  localparam logic [1:0]       PLANE_LAST   = 2'(NUM_HALF - 1);

  state_e              state_q;
  logic                mode_q;
  logic [INT_W-1:0]    int_q;
  logic [HALF_W-1:0]   half_q;

  state_e              adv_state;
  logic [1:0]          adv_plane;
  logic [IDX_W-1:0]    adv_idx;
  logic                adv_last;
  logic [ROW_W-1:0]    adv_data;
  logic [ROW_W-1:0]    col_c;
  logic [IDX_W-1:0]    start_row_c;
  logic [ROW_W-1:0]    start_data_c;

  // out_plane/out_index double as the position of the beat currently presented.
  always_comb begin
    adv_state = state_q;
    adv_plane = out_plane;
    adv_idx   = out_index;
    case (state_q)
      ST_INT_ROW: begin
        if (out_index == (mode_q ? CENTER_LAST : ROW_END_FULL)) begin
          adv_state = ST_INT_COL;
          adv_idx   = CENTER_FIRST;
        end else begin
          adv_idx = out_index + IDX_W'(1);
        end
      end
      ST_INT_COL: begin
        if (out_index == CENTER_LAST) begin
          adv_state = ST_HALF;
          adv_plane = mode_q ? PLANE_RED : 2'd0;
          adv_idx   = '0;
        end else begin
          adv_idx = out_index + IDX_W'(1);
        end
      end
      ST_HALF: begin
        if (out_index == HALF_END) begin
          if (mode_q || out_plane == PLANE_LAST) begin
            adv_state = ST_DONE;
          end else begin
            adv_plane = out_plane + 2'd1;
            adv_idx   = '0;
          end
        end else begin
          adv_idx = out_index + IDX_W'(1);
        end
      end
      default: ;
    endcase
    adv_last = (adv_state == ST_HALF) && (adv_idx == HALF_END) &&
               (mode_q || adv_plane == PLANE_LAST);
  end

  interp_column_extract #(
    .WIN     (WIN),
    .PIXEL_W (PIXEL_W),
    .IDX_W   (IDX_W)
  ) u_column_extract (
    .pixels   (int_q),
    .col      (adv_idx),
    .column_c (col_c)
  );

  // Window payload for the upcoming beat, taken from the latched copies.
  always_comb begin
    adv_data = '0;
    case (adv_state)
      ST_INT_ROW: adv_data = int_q[ROW_W*int'(adv_idx) +: ROW_W];
      ST_INT_COL: adv_data = col_c;
      ST_HALF:    adv_data = half_q[ROW_W*(NUM_PIXEL*int'(adv_plane) + int'(adv_idx)) +: ROW_W];
      default:    adv_data = '0;
    endcase
  end

  // The first beat is read straight from the input array since the latch fills on the same edge.
  always_comb begin
    start_row_c  = mode ? CENTER_FIRST : '0;
    start_data_c = integer_array[ROW_W*int'(start_row_c) +: ROW_W];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      int_q     <= '0;
      half_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_kind  <= '0;
      out_plane <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_INT_ROW;
            mode_q    <= mode;
            int_q     <= integer_array;
            half_q    <= half_array;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_data  <= start_data_c;
            out_kind  <= KIND_INT_ROW;
            out_plane <= '0;
            out_index <= start_row_c;
            out_last  <= 1'b0;
          end
        end
        ST_INT_ROW, ST_INT_COL, ST_HALF: begin
          if (out_ready) begin
            state_q <= adv_state;
            if (adv_state == ST_DONE) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_data  <= '0;
              out_kind  <= '0;
              out_plane <= '0;
              out_index <= '0;
              out_last  <= 1'b0;
            end else begin
              out_data  <= adv_data;
              out_kind  <= kind_of_state(adv_state);
              out_plane <= (adv_state == ST_HALF) ? adv_plane : 2'd0;
              out_index <= adv_idx;
              out_last  <= adv_last;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef INTERP_SEQ_STALL_CNT_EN
  // Saturating count of cycles a beat was offered but not taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (state_q == ST_IDLE && start) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_interp_window_sequencer.sv
// Randomized bench for interp_window_sequencer against a beat-list reference model.
module tb_interp_window_sequencer;

  localparam int WIN = 15;
  localparam int NP  = 8;
  localparam int PW  = 8;
  localparam int NH  = 3;
  localparam int OFF = 3;
  localparam int IW  = 4;
`ifdef INTERP_SEQ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    logic [WIN*PW-1:0] data;
    logic [1:0]        kind;
    logic [1:0]        plane;
    logic [IW-1:0]     idx;
    logic              last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic                     mode;
  logic [WIN*WIN*PW-1:0]    integer_array;
  logic [NH*NP*WIN*PW-1:0]  half_array;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIN*PW-1:0]        out_data;
  logic [1:0]               out_kind;
  logic [1:0]               out_plane;
  logic [IW-1:0]            out_index;
  logic                     out_last;
  logic                     busy;
  logic                     done;
  logic [15:0]              stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pix [WIN][WIN];
  logic [7:0] hp  [NH][NP][WIN];
  beat_t      exp_q[$];

  interp_window_sequencer dut (
    .clock         (clk),
    .reset         (rst_n),
    .start         (start),
    .mode          (mode),
    .integer_array (integer_array),
    .half_array    (half_array),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_kind      (out_kind),
    .out_plane     (out_plane),
    .out_index     (out_index),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pack_inputs();
    for (int r = 0; r < WIN; r++)
      for (int j = 0; j < WIN; j++)
        integer_array[(r*WIN+j)*PW +: PW] = pix[r][j];
    for (int p = 0; p < NH; p++)
      for (int i = 0; i < NP; i++)
        for (int j = 0; j < WIN; j++)
          half_array[((p*NP+i)*WIN+j)*PW +: PW] = hp[p][i][j];
  endtask

  task automatic randomize_arrays();
    for (int r = 0; r < WIN; r++)
      for (int j = 0; j < WIN; j++)
        pix[r][j] = 8'($urandom);
    for (int p = 0; p < NH; p++)
      for (int i = 0; i < NP; i++)
        for (int j = 0; j < WIN; j++)
          hp[p][i][j] = 8'($urandom);
  endtask

  // Expected beat list: rows, then centre columns, then half-pel entries.
  task automatic build_model(input bit m);
    beat_t b;
    int    nrows;
    int    r0;
    exp_q.delete();
    nrows = m ? NP : WIN;
    r0    = m ? OFF : 0;
    for (int k = 0; k < nrows; k++) begin
      b.kind = 2'd0; b.plane = 2'd0; b.idx = IW'(r0 + k); b.last = 1'b0;
      for (int j = 0; j < WIN; j++) b.data[j*PW +: PW] = pix[r0+k][j];
      exp_q.push_back(b);
    end
    for (int k = 0; k < NP; k++) begin
      b.kind = 2'd1; b.plane = 2'd0; b.idx = IW'(OFF + k); b.last = 1'b0;
      for (int j = 0; j < WIN; j++) b.data[j*PW +: PW] = pix[j][OFF+k];
      exp_q.push_back(b);
    end
    for (int p = 0; p < NH; p++) begin
      if (!m || p == NH/2) begin
        for (int i = 0; i < NP; i++) begin
          b.kind = 2'd2; b.plane = 2'(p); b.idx = IW'(i); b.last = 1'b0;
          for (int j = 0; j < WIN; j++) b.data[j*PW +: PW] = hp[p][i][j];
          exp_q.push_back(b);
        end
      end
    end
    b = exp_q.pop_back();
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready pattern 1,0,0,1 then high.
  task automatic run_seq(input bit m, input int rmode, input bit poke_start, input bit scramble);
    int    cyc;
    int    beats;
    int    total;
    int    stall_exp;
    bit    rdy;
    beat_t e;
    build_model(m);
    total     = exp_q.size();
    stall_exp = 0;
    beats     = 0;
    cyc       = 0;
    pack_inputs();
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      check("valid", 128'(out_valid), 128'(1));
      check("busy", 128'(busy), 128'(1));
      check("done_low", 128'(done), 128'(0));
      e = exp_q[0];
      check("data", 128'(out_data), 128'(e.data));
      check("kind", 128'(out_kind), 128'(e.kind));
      check("plane", 128'(out_plane), 128'(e.plane));
      check("index", 128'(out_index), 128'(e.idx));
      check("last", 128'(out_last), 128'(e.last));
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(cyc == 1 || cyc == 2);
      endcase
      out_ready = rdy;
      if (out_valid && rdy) begin
        void'(exp_q.pop_front());
        beats++;
      end else if (out_valid && STALL_EN) begin
        stall_exp++;
      end
      if (poke_start) start = 1'($urandom_range(0, 1));
      if (scramble) begin
        randomize_arrays();
        pack_inputs();
        mode = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) check("timeout", 128'(1), 128'(0));
    check("beat_count", 128'(beats), 128'(total));
    check("done_pulse", 128'(done), 128'(1));
    check("busy_done", 128'(busy), 128'(0));
    check("valid_done", 128'(out_valid), 128'(0));
    check("last_done", 128'(out_last), 128'(0));
    check("stall_count", 128'(stall_count), 128'(stall_exp));
    start = poke_start;
    @(negedge clk);
    start = 1'b0;
    check("done_clear", 128'(done), 128'(0));
    check("valid_idle", 128'(out_valid), 128'(0));
    check("busy_idle", 128'(busy), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_last"}, 128'(out_last), 128'(0));
    check({tag, "_data"}, 128'(out_data), 128'(0));
    check({tag, "_kind"}, 128'(out_kind), 128'(0));
    check({tag, "_plane"}, 128'(out_plane), 128'(0));
    check({tag, "_index"}, 128'(out_index), 128'(0));
    check({tag, "_stall"}, 128'(stall_count), 128'(0));
  endtask

  task automatic reset_mid_sequence();
    randomize_arrays();
    pack_inputs();
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    mode      = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_index", 128'(out_index), 128'(10));
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    mode          = 1'b0;
    out_ready     = 1'b0;
    integer_array = '0;
    half_array    = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int r = 0; r < WIN; r++)
      for (int j = 0; j < WIN; j++)
        pix[r][j] = 8'(16*r + j);
    for (int p = 0; p < NH; p++)
      for (int i = 0; i < NP; i++)
        for (int j = 0; j < WIN; j++)
          hp[p][i][j] = 8'($urandom);
    run_seq(1'b0, 0, 1'b0, 1'b0);

    randomize_arrays();
    run_seq(1'b1, 0, 1'b0, 1'b0);
    randomize_arrays();
    run_seq(1'b0, 2, 1'b0, 1'b0);
    randomize_arrays();
    run_seq(1'b1, 2, 1'b0, 1'b0);
    randomize_arrays();
    run_seq(1'b0, 1, 1'b1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      randomize_arrays();
      run_seq(1'($urandom), 1, 1'($urandom), 1'($urandom));
    end

    reset_mid_sequence();
    randomize_arrays();
    run_seq(1'b0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
